// File: rtl/elbeth_fetch_unit.sv
// ELBETH instruction-fetch stage: PC, imem req/ack handshake, one-entry skid buffer, field split.
// Optional misaligned-branch trap is enabled with `define ELBETH_FETCH_MISALIGN_TRAP_EN.
module elbeth_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    input  logic        id_stall,
    input  logic        ex_branch_taken,
    input  logic [31:0] ex_branch_target,
    output logic        if_valid,
    output logic [31:0] if_pc,
`ifdef ELBETH_FETCH_MISALIGN_TRAP_EN
    output logic        if_misaligned,
`endif
    output logic [6:0]  opcode,
    output logic [4:0]  inst_0,
    output logic [2:0]  inst_1,
    output logic [4:0]  inst_2,
    output logic [4:0]  inst_3,
    output logic [6:0]  inst_4
);

    typedef enum logic [2:0] {
        S_BOOT = 3'd0,
        S_REQ  = 3'd1,
        S_FULL = 3'd2,
        S_DROP = 3'd3,
        S_PARK = 3'd4
    } state_e;

    state_e      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_redirect_pc;
    logic        r_valid;
    logic [31:0] r_if_pc;
    logic [31:0] r_word;
    logic [31:0] r_skid_word;
    logic [31:0] r_skid_pc;

    logic        w_slot_free;
    logic        w_hold;
    logic        w_mis_tgt;

`ifdef ELBETH_FETCH_MISALIGN_TRAP_EN
    logic        r_misaligned;
    logic        r_park_pending;

    // A parked trap is never consumed by ID; it stays until the next redirect.
    assign w_hold        = r_misaligned;
    assign w_mis_tgt     = (ex_branch_target[1:0] != 2'b00);
    assign if_misaligned = r_misaligned;
`else
    assign w_hold        = 1'b0;
    assign w_mis_tgt     = 1'b0;
`endif

    assign w_slot_free = (!r_valid || !id_stall) && !w_hold;

    // During S_DROP r_pc still holds the stale request address, so the
    // outstanding request keeps a stable address until its ack.
    assign imem_addr = r_pc;
    assign imem_req  = (r_state == S_REQ) || (r_state == S_DROP);

    assign if_valid = r_valid;
    assign if_pc    = r_if_pc;
    assign opcode   = r_word[6:0];
    assign inst_0   = r_word[11:7];
    assign inst_1   = r_word[14:12];
    assign inst_2   = r_word[19:15];
    assign inst_3   = r_word[24:20];
    assign inst_4   = r_word[31:25];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_BOOT;
            r_pc           <= RESET_PC;
            r_redirect_pc  <= RESET_PC;
            r_valid        <= 1'b0;
            r_if_pc        <= 32'h0;
            r_word         <= 32'h0;
            r_skid_word    <= 32'h0;
            r_skid_pc      <= 32'h0;
`ifdef ELBETH_FETCH_MISALIGN_TRAP_EN
            r_misaligned   <= 1'b0;
            r_park_pending <= 1'b0;
`endif
        end else if (ex_branch_taken) begin
            r_valid     <= 1'b0;
            r_skid_word <= 32'h0;
            r_skid_pc   <= 32'h0;
            case (r_state)
                S_REQ: begin
                    if (imem_ack) begin
                        r_pc    <= ex_branch_target;
                        r_state <= S_REQ;
                    end else begin
                        r_redirect_pc <= ex_branch_target;
                        r_state       <= S_DROP;
                    end
                end
                S_DROP: r_redirect_pc <= ex_branch_target;
                default: begin
                    r_pc    <= ex_branch_target;
                    r_state <= S_REQ;
                end
            endcase
`ifdef ELBETH_FETCH_MISALIGN_TRAP_EN
            if (w_mis_tgt) begin
                r_valid      <= 1'b1;
                r_misaligned <= 1'b1;
                r_if_pc      <= ex_branch_target;
                r_word       <= 32'h0;
                if ((r_state == S_DROP) || ((r_state == S_REQ) && !imem_ack)) begin
                    r_state        <= S_DROP;
                    r_park_pending <= 1'b1;
                end else begin
                    r_state        <= S_PARK;
                    r_park_pending <= 1'b0;
                end
            end else begin
                r_misaligned   <= 1'b0;
                r_park_pending <= 1'b0;
            end
`endif
        end else begin
            // A free slot empties the output register unless something reloads it below.
            if (w_slot_free) begin
                r_valid <= 1'b0;
            end
            case (r_state)
                S_BOOT: r_state <= S_REQ;
                S_REQ: begin
                    if (imem_ack) begin
                        r_pc <= r_pc + PC_STEP;
                        if (w_slot_free) begin
                            r_valid <= 1'b1;
                            r_word  <= imem_data;
                            r_if_pc <= r_pc;
                        end else begin
                            r_skid_word <= imem_data;
                            r_skid_pc   <= r_pc;
                            r_state     <= S_FULL;
                        end
                    end
                end
                S_FULL: begin
                    if (w_slot_free) begin
                        r_valid     <= 1'b1;
                        r_word      <= r_skid_word;
                        r_if_pc     <= r_skid_pc;
                        r_skid_word <= 32'h0;
                        r_skid_pc   <= 32'h0;
                        r_state     <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_ack) begin
                        r_pc <= r_redirect_pc;
`ifdef ELBETH_FETCH_MISALIGN_TRAP_EN
                        r_state        <= r_park_pending ? S_PARK : S_REQ;
                        r_park_pending <= 1'b0;
`else
                        r_state <= S_REQ;
`endif
                    end
                end
                S_PARK: r_state <= S_PARK;
                default: r_state <= S_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_elbeth_fetch_unit.sv
// Self-checking bench for elbeth_fetch_unit: transaction-level model (expected fetch address,
// queue of delivered-but-unconsumed instructions) compared every cycle, plus literal checks.
module tb_elbeth_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_data = 32'h0;
    logic        id_stall = 1'b0;
    logic        ex_branch_taken = 1'b0;
    logic [31:0] ex_branch_target = 32'h0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [6:0]  opcode;
    logic [4:0]  inst_0;
    logic [2:0]  inst_1;
    logic [4:0]  inst_2;
    logic [4:0]  inst_3;
    logic [6:0]  inst_4;
`ifdef ELBETH_FETCH_MISALIGN_TRAP_EN
    logic        if_misaligned;
`endif

    elbeth_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (32'd4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_addr        (imem_addr),
        .imem_req         (imem_req),
        .imem_ack         (imem_ack),
        .imem_data        (imem_data),
        .id_stall         (id_stall),
        .ex_branch_taken  (ex_branch_taken),
        .ex_branch_target (ex_branch_target),
        .if_valid         (if_valid),
        .if_pc            (if_pc),
`ifdef ELBETH_FETCH_MISALIGN_TRAP_EN
        .if_misaligned    (if_misaligned),
`endif
        .opcode           (opcode),
        .inst_0           (inst_0),
        .inst_1           (inst_1),
        .inst_2           (inst_2),
        .inst_3           (inst_3),
        .inst_4           (inst_4)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Memory image: address-based pattern, with one known RISC-V add at 0x100.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h00A5_0533;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Model state
    logic [31:0] m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_stale;
    bit          m_drop;
    bit          m_boot;
    bit          m_en = 1'b0;
    bit          m_mis = 1'b0;
    logic [31:0] m_mis_pc = 32'h0;

    // Memory responder state
    int ack_delay = 0;
    int wait_cnt  = 0;

    task automatic model_reset();
        m_q.delete();
        m_pc     = 32'h0;
        m_stale  = 32'h0;
        m_drop   = 1'b0;
        m_boot   = 1'b1;
        m_mis    = 1'b0;
        m_mis_pc = 32'h0;
        wait_cnt = 0;
    endtask

    // One cycle of stimulus; outputs of the new cycle are visible on return.
    task automatic cycle(input bit stall, input bit br, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        id_stall         = stall;
        ex_branch_taken  = br;
        ex_branch_target = tgt;
        imem_ack         = imem_req && (wait_cnt >= ack_delay);
        imem_data        = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
        if (imem_req && !imem_ack) wait_cnt++;
        else wait_cnt = 0;
    endtask

    // Compare DUT against the model, then advance the model over the coming edge.
    always @(negedge clk) begin
        bit exp_req;
        if (m_en) begin
            exp_req = !m_boot && (m_drop || (!m_mis && (m_q.size() < 2)));
            check("imem_req", imem_req, exp_req);
            if (exp_req) check("imem_addr", imem_addr, m_drop ? m_stale : m_pc);
            if (m_mis) begin
                check("trap_valid", if_valid, 1);
                check("trap_pc", if_pc, m_mis_pc);
                check("trap_fields", {inst_4, inst_3, inst_2, inst_1, inst_0, opcode}, 0);
            end else if (m_q.size() > 0) begin
                check("if_valid", if_valid, 1);
                check("if_pc", if_pc, m_q[0]);
                check("fields", {inst_4, inst_3, inst_2, inst_1, inst_0, opcode},
                      mem_word(m_q[0]));
            end else begin
                check("if_valid_low", if_valid, 0);
            end
`ifdef ELBETH_FETCH_MISALIGN_TRAP_EN
            check("if_misaligned", if_misaligned, m_mis);
`endif
            if (ex_branch_taken) begin
                m_q.delete();
                if (!m_drop && exp_req && !imem_ack) begin
                    m_drop  = 1'b1;
                    m_stale = m_pc;
                end
                m_pc = ex_branch_target;
`ifdef ELBETH_FETCH_MISALIGN_TRAP_EN
                m_mis    = (ex_branch_target[1:0] != 2'b00);
                m_mis_pc = ex_branch_target;
`endif
            end else begin
                if (m_q.size() > 0 && !id_stall && !m_mis) void'(m_q.pop_front());
                if (exp_req && imem_ack) begin
                    if (m_drop) begin
                        m_drop = 1'b0;
                    end else begin
                        m_q.push_back(m_pc);
                        m_pc = m_pc + 32'd4;
                    end
                end
            end
            m_boot = 1'b0;
        end
    end

    task automatic release_reset();
        @(posedge clk);
        #1;
        imem_ack        = 1'b0;
        ex_branch_taken = 1'b0;
        id_stall        = 1'b0;
        rst             = 1'b0;
        model_reset();
        m_en = 1'b1;
    endtask

    initial begin
        #1;
        check("rst_req", imem_req, 0);
        check("rst_valid", if_valid, 0);
        check("rst_pc", if_pc, 0);
        ack_delay = 0;
        release_reset();

        // Zero-wait sequential fetch
        cycle(0, 0, 0);
        check("first_addr", imem_addr, 32'h0);
        check("first_valid_low", if_valid, 0);
        cycle(0, 0, 0);
        check("first_valid", if_valid, 1);
        check("first_pc", if_pc, 32'h0);

        // Branch to 0x100 while the fetch of 0x8 waits two cycles for its ack
        ack_delay = 2;
        cycle(0, 1, 32'h100);
        check("pend_addr", imem_addr, 32'h8);
        check("pend_pc", if_pc, 32'h4);
        cycle(0, 0, 0);
        check("br_valid_low", if_valid, 0);
        check("drop_addr", imem_addr, 32'h8);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        check("redir_addr", imem_addr, 32'h100);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        ack_delay = 0;
        cycle(0, 0, 0);
        check("redir_pc", if_pc, 32'h100);
        check("add_opcode", opcode, 7'h33);
        check("add_rd", inst_0, 5'd10);
        check("add_f3", inst_1, 3'd0);
        check("add_rs1", inst_2, 5'd10);
        check("add_rs2", inst_3, 5'd10);
        check("add_f7", inst_4, 7'h00);

        // Back-to-back throughput
        for (int i = 0; i < 5; i++) cycle(0, 0, 0);
        check("stream_pc", if_pc, 32'h114);

        // Stall for three cycles while an ack arrives
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        check("skid_req", imem_req, 0);
        check("skid_hold_pc", if_pc, 32'h118);
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        check("skid_out_pc", if_pc, 32'h11C);
        cycle(0, 0, 0);
        check("after_skid_pc", if_pc, 32'h120);

        // Async reset in the middle of a drop
        ack_delay = 3;
        cycle(0, 1, 32'h40);
        cycle(0, 0, 0);
        @(posedge clk);
        #3;
        m_en     = 1'b0;
        imem_ack = 1'b0;
        rst      = 1'b1;
        #1;
        check("mid_rst_req", imem_req, 0);
        check("mid_rst_valid", if_valid, 0);
        check("mid_rst_pc", if_pc, 0);
        check("mid_rst_fields", {inst_4, inst_3, inst_2, inst_1, inst_0, opcode}, 0);
        check("mid_rst_addr", imem_addr, 32'h0);
        ack_delay = 0;
        release_reset();
        cycle(0, 0, 0);
        check("restart_addr", imem_addr, 32'h0);
        check("restart_req", imem_req, 1);
        cycle(0, 0, 0);
        check("restart_pc", if_pc, 32'h0);
        for (int i = 0; i < 3; i++) cycle(i == 1, 0, 0);

`ifdef ELBETH_FETCH_MISALIGN_TRAP_EN
        cycle(0, 1, 32'h102);
        cycle(0, 0, 0);
        check("mis_flag", if_misaligned, 1);
        check("mis_pc", if_pc, 32'h102);
        check("mis_req", imem_req, 0);
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        check("mis_park_req", imem_req, 0);
        cycle(0, 1, 32'h200);
        cycle(0, 0, 0);
        check("mis_clear", if_misaligned, 0);
        check("mis_redir_addr", imem_addr, 32'h200);
        cycle(0, 0, 0);
        check("mis_redir_pc", if_pc, 32'h200);
`endif

        cycle(0, 0, 0);
        m_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/elbeth_fetch_unit.md
Name: elbeth_fetch_unit

Overview:
- Instruction-fetch stage of the ELBETH core. Produces the instruction stream consumed by elbeth_decoder.
- Holds the PC and runs a req/ack handshake with instruction memory.
- Splits each fetched word into the field bundle the decoder expects (opcode, inst_0..inst_4), with a valid/stall handshake toward ID.
- Handles branch redirects from EX, including discarding an in-flight fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- PC_STEP, 4, byte increment between sequential fetches.

Ports:
- clk  in  1  core clock; all state on rising edge.
- rst  in  1  asynchronous reset, active-high.
- imem_addr  out  32  fetch address; equals pc while imem_req=1.
- imem_req  out  1  fetch request; held with stable addr until imem_ack.
- imem_ack  in  1  one-cycle pulse; imem_data valid this cycle; may arrive in the first req cycle.
- imem_data  in  32  fetched instruction word.
- id_stall  in  1  decoder cannot accept this cycle.
- ex_branch_taken  in  1  redirect request (one-cycle pulse).
- ex_branch_target  in  32  redirect address.
- if_valid  out  1  field outputs hold a valid instruction.
- if_pc  out  32  address of the presented instruction.
- opcode  out  7  instr[6:0].
- inst_0  out  5  instr[11:7] (rd).
- inst_1  out  3  instr[14:12] (funct3).
- inst_2  out  5  instr[19:15] (rs1).
- inst_3  out  5  instr[24:20] (rs2).
- inst_4  out  7  instr[31:25] (funct7).

Behaviour:
- Reset (async, any cycle, including mid-request):
  - pc=RESET_PC; state=S_BOOT; imem_req=0; if_valid=0; if_pc=0; all field outputs 0; skid buffer empty.
  - Any outstanding ack is forgotten.
- Slot free = !if_valid || !id_stall. The output register loads on a free slot: from the skid buffer if full, else from a fresh ack.
- States:
  - S_BOOT: one idle cycle, then S_REQ.
  - S_REQ: imem_req=1, imem_addr=pc. On imem_ack:
    - Slot free: load outputs with imem_data and if_pc=pc.
    - Slot not free: store data+pc in the one-entry skid buffer and go to S_FULL.
    - In both cases pc += PC_STEP (mod 2^32, wraps silently).
    - Stay in S_REQ only if the skid buffer remains empty.
  - S_FULL: imem_req=0. When the slot frees, the buffer moves to the outputs and the state returns to S_REQ on the next cycle.
  - S_DROP: imem_req=1 with the stale address; no pc update. Wait for imem_ack, discard the data, then go to S_REQ with the redirected pc.
- Branch (ex_branch_taken=1) has priority over every other event in the same cycle:
  - if_valid<=0, skid buffer cleared, pc<=ex_branch_target.
  - In S_REQ with no ack this cycle: next state S_DROP (the in-flight request must still complete).
  - In S_REQ with ack this cycle: data discarded, next state S_REQ at the target.
  - In S_FULL or S_BOOT: next state S_REQ.
  - In S_DROP: pc updates to the new target; remain in S_DROP.
- Latency: req→ack in the same cycle → if_valid high the next cycle. Sustained throughput is 1 instr/cycle with zero-wait memory and no stall.
- if_valid with fields stays stable while id_stall=1. Fields always equal the bit-slices of the stored word.
- imem_addr is driven from pc every cycle; it is only meaningful while imem_req=1.

Optional Feature:
- Macro: ELBETH_FETCH_MISALIGN_TRAP_EN.
- Enabled:
  - Adds output if_misaligned (1 bit), registered.
  - A branch target with [1:0]!=0 is not fetched. Instead:
    - if_valid=1, if_misaligned=1, if_pc=target, fields=0, no imem_req.
    - FSM parks in S_FULL-equivalent until the next branch.
    - If the redirect cycle was in S_REQ with no ack, the in-flight fetch still drains (S_DROP) before parking, with imem_req=0 while parked.
  - Reset value of if_misaligned is 0.
- Disabled: no port; target[1:0] is ignored and the fetch address uses the target as given.

Test Plan:
- Reset with RESET_PC=0, zero-wait memory (ack in the req cycle), data = addr-based pattern → imem_addr 0,4,8,...; if_valid rises 1 cycle after the first ack; opcode/inst_0..4 match the slices of each word.
- Load word 32'h00A50533 → opcode=7'h33, inst_0=5'd10, inst_1=3'd0, inst_2=5'd10, inst_3=5'd10, inst_4=7'h00.
- Hold id_stall=1 for 3 cycles while an ack arrives → skid buffer captures it, imem_req=0; outputs unchanged; after stall drops, the buffered instr is presented next cycle with no loss or duplication.
- Branch to 32'h100 while a request at 32'h8 is pending (ack 2 cycles later) → if_valid=0 immediately; ack for 0x8 discarded; next imem_addr=0x100; first valid if_pc=0x100.
- Assert rst mid-S_DROP → all outputs zero asynchronously; after release, fetch restarts at RESET_PC.
- With ELBETH_FETCH_MISALIGN_TRAP_EN, branch to 32'h102 → if_misaligned=1, if_pc=0x102, no imem_req until a new branch to 0x200.
